// File: rtl/ct_ifu_dbg_snap_ctrl_pkg.sv
// Shared widths, readout beat layout and FSM encodings for the IFU debug snapshot controller.
package ct_ifu_dbg_snap_ctrl_pkg;

    localparam int DBG_INFO_W = 83;
    localparam int SRC_W      = 2;
    localparam int SNAP_W     = DBG_INFO_W + SRC_W;
    localparam int RD_BEATS   = 3;
    localparam int BEAT_W     = 32;
    localparam int PAD_W      = RD_BEATS * BEAT_W - SNAP_W;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_B0   = 2'd1,
        RD_B1   = 2'd2,
        RD_B2   = 2'd3
    } rd_state_e;

    // Beat 2 carries the top 19 info bits with the source tag just above them.
    function automatic logic [BEAT_W-1:0] beat_sel(input logic [SNAP_W-1:0] snap,
                                                   input logic [1:0]        beat);
        logic [BEAT_W-1:0] w_beat;
        case (beat)
            2'd0:    w_beat = snap[BEAT_W-1:0];
            2'd1:    w_beat = snap[2*BEAT_W-1:BEAT_W];
            default: w_beat = {{PAD_W{1'b0}}, snap[SNAP_W-1:2*BEAT_W]};
        endcase
        return w_beat;
    endfunction

endpackage

// File: rtl/ct_ifu_dbg_snap_ctrl_if.sv
// IFU/HAD-side signal bundle of the snapshot controller; slave = controller, master = HAD/IFU side.
interface ct_ifu_dbg_snap_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int WD_W  = 10
);
    import ct_ifu_dbg_snap_ctrl_pkg::*;
    localparam int IDX_W = $clog2(DEPTH);

    logic [DBG_INFO_W-1:0] dbg_info_in;
    logic                  had_rtu_xx_jdbreq;
    logic                  rtu_ifu_xx_dbgon;
    logic                  ifu_progress;
    logic                  had_ifu_wd_en;
    logic [WD_W-1:0]       had_ifu_wd_thresh;
    logic                  had_ifu_clr;
    logic                  had_ifu_rd_req;
    logic [IDX_W-1:0]      had_ifu_rd_idx;
    logic                  ifu_had_rd_ack;
    logic [BEAT_W-1:0]     ifu_had_rd_data;
    logic                  ifu_had_rd_last;
    logic [IDX_W:0]        ifu_had_snap_cnt;
    logic                  ifu_had_wd_hit;

    modport slave (
        input  dbg_info_in, had_rtu_xx_jdbreq, rtu_ifu_xx_dbgon, ifu_progress,
               had_ifu_wd_en, had_ifu_wd_thresh, had_ifu_clr, had_ifu_rd_req, had_ifu_rd_idx,
        output ifu_had_rd_ack, ifu_had_rd_data, ifu_had_rd_last, ifu_had_snap_cnt, ifu_had_wd_hit
    );

    modport master (
        output dbg_info_in, had_rtu_xx_jdbreq, rtu_ifu_xx_dbgon, ifu_progress,
               had_ifu_wd_en, had_ifu_wd_thresh, had_ifu_clr, had_ifu_rd_req, had_ifu_rd_idx,
        input  ifu_had_rd_ack, ifu_had_rd_data, ifu_had_rd_last, ifu_had_snap_cnt, ifu_had_wd_hit
    );

endinterface

// File: rtl/ct_ifu_dbg_snap_buf.sv
// Snapshot history ring: DEPTH flop entries, one write port, one combinational read port.
module ct_ifu_dbg_snap_buf
    import ct_ifu_dbg_snap_ctrl_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic              i_clr,
    input  logic [SNAP_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]  i_rd_addr,
    output logic [SNAP_W-1:0] o_rd_data,
    output logic [IDX_W-1:0]  o_wr_ptr,
    output logic [IDX_W:0]    o_cnt
);

    localparam logic [IDX_W:0] CNT_FULL = (IDX_W + 1)'(DEPTH);

    logic [SNAP_W-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0]  r_wr_ptr;
    logic [IDX_W:0]    r_cnt;

    // Storage is deliberately unreset; validity is tracked by r_cnt alone.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (i_wr_en && (r_wr_ptr == IDX_W'(gi))) begin
                r_mem[gi] <= i_wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_cnt != CNT_FULL) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
    assign o_wr_ptr  = r_wr_ptr;
    assign o_cnt     = r_cnt;

endmodule

// File: rtl/ct_ifu_dbg_snap_ctrl.sv
// IFU debug snapshot controller: trigger detection, no-progress watchdog and 3-beat HAD readout.
module ct_ifu_dbg_snap_ctrl
    import ct_ifu_dbg_snap_ctrl_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WD_W  = 10,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    ct_ifu_dbg_snap_ctrl_if.slave bus
);

    logic              r_jdb_prev;
    logic [WD_W-1:0]   r_wd_cnt;
    logic              r_wd_hit;
    logic [SNAP_W-1:0] r_shadow;
    rd_state_e         r_state;
    rd_state_e         w_state_next;

    logic              w_jdb_lvl;
    logic              w_jdb_trig;
    logic              w_wd_trig;
    logic              w_wd_clr;
    logic              w_cap;
    logic [IDX_W-1:0]  w_wr_ptr;
    logic [IDX_W:0]    w_snap_cnt;
    logic [IDX_W-1:0]  w_rd_addr;
    logic [SNAP_W-1:0] w_rd_entry;
    logic              w_rd_valid;
    logic              w_accept;
    logic [1:0]        w_beat_idx;

    assign w_jdb_lvl  = bus.had_rtu_xx_jdbreq & ~bus.rtu_ifu_xx_dbgon;
    assign w_jdb_trig = w_jdb_lvl & ~r_jdb_prev;
    assign w_wd_trig  = (bus.had_ifu_wd_thresh != '0) && (r_wd_cnt == bus.had_ifu_wd_thresh);
    assign w_wd_clr   = bus.ifu_progress | ~bus.had_ifu_wd_en | bus.rtu_ifu_xx_dbgon | bus.had_ifu_clr;
    assign w_cap      = (w_jdb_trig | w_wd_trig) & ~bus.had_ifu_clr;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_jdb_prev <= 1'b0;
            r_wd_cnt   <= '0;
            r_wd_hit   <= 1'b0;
        end else begin
            r_jdb_prev <= w_jdb_lvl;
            r_wd_cnt   <= (w_wd_clr || w_wd_trig) ? '0 : r_wd_cnt + 1'b1;
            if (bus.had_ifu_clr) begin
                r_wd_hit <= 1'b0;
            end else if (w_wd_trig) begin
                r_wd_hit <= 1'b1;
            end
        end
    end

    ct_ifu_dbg_snap_buf #(.DEPTH(DEPTH)) u_buf (
        .clk       (forever_cpuclk),
        .rst_n     (cpurst_b),
        .i_wr_en   (w_cap),
        .i_clr     (bus.had_ifu_clr),
        .i_wr_data ({w_wd_trig, w_jdb_trig, bus.dbg_info_in}),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_entry),
        .o_wr_ptr  (w_wr_ptr),
        .o_cnt     (w_snap_cnt)
    );

    // Index 0 is the newest entry, i.e. the slot just behind the write pointer.
    assign w_rd_addr  = w_wr_ptr - IDX_W'(1) - bus.had_ifu_rd_idx;
    assign w_rd_valid = {1'b0, bus.had_ifu_rd_idx} < w_snap_cnt;
    assign w_accept   = (r_state == RD_IDLE) && bus.had_ifu_rd_req;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state  <= RD_IDLE;
            r_shadow <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_shadow <= w_rd_valid ? w_rd_entry : '0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RD_IDLE: if (bus.had_ifu_rd_req) w_state_next = RD_B0;
            RD_B0:   w_state_next = RD_B1;
            RD_B1:   w_state_next = RD_B2;
            RD_B2:   w_state_next = RD_IDLE;
            default: w_state_next = RD_IDLE;
        endcase
    end

    assign w_beat_idx           = 2'(r_state) - 2'd1;
    assign bus.ifu_had_rd_ack   = (r_state != RD_IDLE);
    assign bus.ifu_had_rd_data  = bus.ifu_had_rd_ack ? beat_sel(r_shadow, w_beat_idx) : '0;
    assign bus.ifu_had_rd_last  = bus.ifu_had_rd_ack && (w_beat_idx == 2'(RD_BEATS - 1));
    assign bus.ifu_had_snap_cnt = w_snap_cnt;
    assign bus.ifu_had_wd_hit   = r_wd_hit;

endmodule

// File: tb/tb_ct_ifu_dbg_snap_ctrl.sv
// Scoreboard bench for the IFU debug snapshot controller: directed stimulus, beat monitor on negedge.
module tb_ct_ifu_dbg_snap_ctrl;
    import ct_ifu_dbg_snap_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int WD_W  = 10;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    beat_t exp_q[$];
    beat_t mon_e;
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    ct_ifu_dbg_snap_ctrl_if #(.DEPTH(DEPTH), .WD_W(WD_W)) bus ();

    ct_ifu_dbg_snap_ctrl #(.DEPTH(DEPTH), .WD_W(WD_W)) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .bus            (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ifu_had_rd_ack) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got data=%h last=%b want no beat",
                             bus.ifu_had_rd_data, bus.ifu_had_rd_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("beat data=%h last=%b (want %h/%b)", bus.ifu_had_rd_data,
                             bus.ifu_had_rd_last, mon_e.data, mon_e.last);
                    chk("beat_data", bus.ifu_had_rd_data, mon_e.data);
                    chk("beat_last", 32'(bus.ifu_had_rd_last), 32'(mon_e.last));
                end
            end else begin
                chk("idle_out", bus.ifu_had_rd_data | 32'(bus.ifu_had_rd_last), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push3(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
        exp_q.push_back('{data: b0, last: 1'b0});
        exp_q.push_back('{data: b1, last: 1'b0});
        exp_q.push_back('{data: b2, last: 1'b1});
    endtask

    task automatic rd(input int idx, input logic [31:0] b0, input logic [31:0] b1,
                      input logic [31:0] b2);
        bus.had_ifu_rd_idx = 2'(idx);
        bus.had_ifu_rd_req = 1'b1;
        push3(b0, b1, b2);
        tick();
        bus.had_ifu_rd_req = 1'b0;
        repeat (4) tick();
        chk("rd_drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic jdb_pulse(input logic [82:0] info);
        bus.dbg_info_in       = info;
        bus.had_rtu_xx_jdbreq = 1'b1;
        tick();
        bus.had_rtu_xx_jdbreq = 1'b0;
        tick();
    endtask

    task automatic clr_pulse();
        bus.had_ifu_clr = 1'b1;
        tick();
        bus.had_ifu_clr = 1'b0;
    endtask

    initial begin
        bus.dbg_info_in       = '0;
        bus.had_rtu_xx_jdbreq = 1'b0;
        bus.rtu_ifu_xx_dbgon  = 1'b0;
        bus.ifu_progress      = 1'b0;
        bus.had_ifu_wd_en     = 1'b0;
        bus.had_ifu_wd_thresh = '0;
        bus.had_ifu_clr       = 1'b0;
        bus.had_ifu_rd_req    = 1'b0;
        bus.had_ifu_rd_idx    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(bus.ifu_had_rd_ack), 32'd0);
        chk("rst_data", bus.ifu_had_rd_data, 32'd0);
        chk("rst_last", 32'(bus.ifu_had_rd_last), 32'd0);
        chk("rst_cnt", 32'(bus.ifu_had_snap_cnt), 32'd0);
        chk("rst_wdhit", 32'(bus.ifu_had_wd_hit), 32'd0);
        rst_n = 1'b1;
        tick();

        // Held jdbreq yields one capture
        bus.dbg_info_in       = 83'h1_2345_6789_ABCD_EF01_2345;
        bus.had_rtu_xx_jdbreq = 1'b1;
        repeat (5) tick();
        bus.had_rtu_xx_jdbreq = 1'b0;
        tick();
        chk("jdb_cnt", 32'(bus.ifu_had_snap_cnt), 32'd1);
        rd(0, 32'hEF01_2345, 32'h6789_ABCD, 32'h0009_2345);

        // Watchdog, thresh 5, no progress
        bus.dbg_info_in       = 83'd7;
        bus.had_ifu_wd_thresh = 10'd5;
        bus.had_ifu_wd_en     = 1'b1;
        repeat (5) tick();
        chk("wd_early", 32'(bus.ifu_had_wd_hit), 32'd0);
        tick();
        chk("wd_hit", 32'(bus.ifu_had_wd_hit), 32'd1);
        chk("wd_cnt", 32'(bus.ifu_had_snap_cnt), 32'd2);
        bus.had_ifu_wd_en = 1'b0;
        rd(0, 32'd7, 32'd0, 32'h0010_0000);
        rd(1, 32'hEF01_2345, 32'h6789_ABCD, 32'h0009_2345);
        clr_pulse();
        chk("clr_cnt", 32'(bus.ifu_had_snap_cnt), 32'd0);
        chk("clr_wdhit", 32'(bus.ifu_had_wd_hit), 32'd0);

        // Watchdog delayed by a progress pulse in cycle 3
        bus.dbg_info_in   = 83'd8;
        bus.had_ifu_wd_en = 1'b1;
        repeat (3) tick();
        bus.ifu_progress = 1'b1;
        tick();
        bus.ifu_progress = 1'b0;
        repeat (5) tick();
        chk("wdp_early", 32'(bus.ifu_had_wd_hit), 32'd0);
        tick();
        chk("wdp_hit", 32'(bus.ifu_had_wd_hit), 32'd1);
        chk("wdp_cnt", 32'(bus.ifu_had_snap_cnt), 32'd1);
        bus.had_ifu_wd_en = 1'b0;
        rd(0, 32'd8, 32'd0, 32'h0010_0000);
        clr_pulse();

        // Ring wrap: six captures into four entries
        for (int v = 1; v <= 6; v++) jdb_pulse(83'(v));
        chk("wrap_cnt", 32'(bus.ifu_had_snap_cnt), 32'd4);
        rd(0, 32'd6, 32'd0, 32'h0008_0000);
        rd(1, 32'd5, 32'd0, 32'h0008_0000);
        rd(2, 32'd4, 32'd0, 32'h0008_0000);
        rd(3, 32'd3, 32'd0, 32'h0008_0000);
        clr_pulse();
        jdb_pulse(83'd9);
        jdb_pulse(83'd10);
        chk("two_cnt", 32'(bus.ifu_had_snap_cnt), 32'd2);
        rd(3, 32'd0, 32'd0, 32'd0);
        rd(1, 32'd9, 32'd0, 32'h0008_0000);

        // jdb edge and watchdog in the same cycle
        clr_pulse();
        bus.dbg_info_in       = 83'h55;
        bus.had_ifu_wd_thresh = 10'd3;
        bus.had_ifu_wd_en     = 1'b1;
        repeat (3) tick();
        bus.had_rtu_xx_jdbreq = 1'b1;
        tick();
        bus.had_rtu_xx_jdbreq = 1'b0;
        bus.had_ifu_wd_en     = 1'b0;
        chk("both_cnt", 32'(bus.ifu_had_snap_cnt), 32'd1);
        chk("both_wdhit", 32'(bus.ifu_had_wd_hit), 32'd1);
        rd(0, 32'h55, 32'd0, 32'h0018_0000);

        // clr wins over a same-cycle trigger
        clr_pulse();
        tick();
        bus.dbg_info_in       = 83'h66;
        bus.had_ifu_clr       = 1'b1;
        bus.had_rtu_xx_jdbreq = 1'b1;
        tick();
        bus.had_ifu_clr       = 1'b0;
        bus.had_rtu_xx_jdbreq = 1'b0;
        tick();
        chk("clrdrop_cnt", 32'(bus.ifu_had_snap_cnt), 32'd0);

        // Capture, clr and a second request during B1
        jdb_pulse(83'hA1);
        chk("a1_cnt", 32'(bus.ifu_had_snap_cnt), 32'd1);
        bus.had_ifu_rd_idx = 2'd0;
        bus.had_ifu_rd_req = 1'b1;
        push3(32'hA1, 32'd0, 32'h0008_0000);
        tick();
        bus.had_ifu_rd_req = 1'b0;
        tick();
        bus.dbg_info_in       = 83'hB2;
        bus.had_ifu_clr       = 1'b1;
        bus.had_rtu_xx_jdbreq = 1'b1;
        bus.had_ifu_rd_req    = 1'b1;
        tick();
        bus.had_ifu_clr       = 1'b0;
        bus.had_rtu_xx_jdbreq = 1'b0;
        bus.had_ifu_rd_req    = 1'b0;
        repeat (3) tick();
        chk("b1_cnt", 32'(bus.ifu_had_snap_cnt), 32'd0);
        chk("b1_drain", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a readout
        bus.dbg_info_in       = 83'hC3;
        bus.had_ifu_wd_thresh = 10'd2;
        bus.had_ifu_wd_en     = 1'b1;
        repeat (3) tick();
        bus.had_ifu_wd_en = 1'b0;
        chk("pre_wdhit", 32'(bus.ifu_had_wd_hit), 32'd1);
        bus.had_ifu_rd_idx = 2'd0;
        bus.had_ifu_rd_req = 1'b1;
        exp_q.push_back('{data: 32'hC3, last: 1'b0});
        tick();
        bus.had_ifu_rd_req = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_ack", 32'(bus.ifu_had_rd_ack), 32'd0);
        chk("mid_data", bus.ifu_had_rd_data, 32'd0);
        chk("mid_last", 32'(bus.ifu_had_rd_last), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post_cnt", 32'(bus.ifu_had_snap_cnt), 32'd0);
        chk("post_wdhit", 32'(bus.ifu_had_wd_hit), 32'd0);
        repeat (4) tick();
        chk("post_drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
